// File: rtl/sync_fifo_param.sv
// sync_fifo_param: single-clock FIFO with almost flags, ack/err handshakes and standard/FWFT read modes
module sync_fifo_param #(
  parameter int SIZE      = 32,
  parameter int DEPTH     = 16,
  parameter int FWFT      = 0,
  parameter int AE_THRESH = 2,
  parameter int AF_THRESH = DEPTH - 2
) (
  input  logic                   clk,
  input  logic                   ainit,
  input  logic                   wr_en,
  input  logic [SIZE-1:0]        din,
  input  logic                   rd_en,
  output logic [SIZE-1:0]        dout,
  output logic                   full_f,
  output logic                   empty_f,
  output logic                   almost_full_f,
  output logic                   almost_empty_f,
  output logic                   wr_ack,
  output logic                   wr_err,
  output logic                   rd_ack,
  output logic                   rd_err,
  output logic [$clog2(DEPTH):0] count
);
  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  if (SIZE < 1 || DEPTH < 4 || (DEPTH & (DEPTH - 1)) != 0 || FWFT < 0 || FWFT > 1 ||
      AE_THRESH < 1 || AE_THRESH >= AF_THRESH || AF_THRESH > DEPTH - 1) begin : g_bad_params
    $error("sync_fifo_param: illegal parameter combination");
  end
  logic [SIZE-1:0] mem [DEPTH];
  logic [PW-1:0]   wptr, rptr, wptr_n, rptr_n, cnt_n;
  logic [SIZE-1:0] head_n, dout_n;
  logic            wr_acc, rd_acc;
  assign wr_acc = wr_en && !full_f;
  assign rd_acc = rd_en && !empty_f;
  assign wptr_n = wptr + PW'(wr_acc);
  assign rptr_n = rptr + PW'(rd_acc);
  assign cnt_n  = wptr_n - rptr_n;
  assign count  = wptr - rptr;
  // next head word bypasses from din when the new head is being written this edge
  always_comb begin
    head_n = (rptr_n == wptr) ? din : mem[rptr_n[AW-1:0]];
    dout_n = (FWFT != 0) ? ((cnt_n != '0) ? head_n : dout) : (rd_acc ? mem[rptr[AW-1:0]] : dout);
  end
  // storage write; reset takes priority so no word lands during ainit
  always_ff @(posedge clk)
    if (!ainit && wr_acc) mem[wptr[AW-1:0]] <= din;
  // pointers, output data and flags registered from next-state occupancy
  always_ff @(posedge clk) begin
    if (ainit) begin
      wptr           <= '0;
      rptr           <= '0;
      dout           <= '0;
      full_f         <= 1'b0;
      empty_f        <= 1'b1;
      almost_full_f  <= 1'b0;
      almost_empty_f <= 1'b1;
      wr_ack         <= 1'b0;
      wr_err         <= 1'b0;
      rd_ack         <= 1'b0;
      rd_err         <= 1'b0;
    end else begin
      wptr           <= wptr_n;
      rptr           <= rptr_n;
      dout           <= dout_n;
      full_f         <= cnt_n == PW'(DEPTH);
      empty_f        <= cnt_n == '0;
      almost_full_f  <= cnt_n >= PW'(AF_THRESH);
      almost_empty_f <= cnt_n <= PW'(AE_THRESH);
      wr_ack         <= wr_acc;
      wr_err         <= wr_en && !wr_acc;
      rd_ack         <= rd_acc;
      rd_err         <= rd_en && !rd_acc;
    end
  end
endmodule

// File: tb/tb_sync_fifo_param.sv
// tb_sync_fifo_param: table vectors, directed corners and random traffic against a queue model, both read modes
module tb_sync_fifo_param;
  logic        clk, ainit, wr_en, rd_en;
  logic [31:0] din;
  logic [31:0] s_dout, f_dout;
  logic [4:0]  s_count, f_count;
  logic        s_full, s_empty, s_af, s_ae, s_wa, s_we, s_ra, s_re;
  logic        f_full, f_empty, f_af, f_ae, f_wa, f_we, f_ra, f_re;
  int          n_chk = 0, n_pass = 0;
  logic [31:0] q[$];
  bit          m_wa, m_we, m_ra, m_re;
  logic [31:0] m_ds, m_df;
  typedef struct {
    bit          r, w, rd;
    logic [31:0] d;
    int          cnt;
    logic [3:0]  ack;
    logic [31:0] ds, df;
  } vec_t;
  vec_t tbl[9];

  sync_fifo_param #(.SIZE(32), .DEPTH(16), .FWFT(0), .AE_THRESH(2), .AF_THRESH(14)) u_std (
    .clk(clk), .ainit(ainit), .wr_en(wr_en), .din(din), .rd_en(rd_en), .dout(s_dout),
    .full_f(s_full), .empty_f(s_empty), .almost_full_f(s_af), .almost_empty_f(s_ae),
    .wr_ack(s_wa), .wr_err(s_we), .rd_ack(s_ra), .rd_err(s_re), .count(s_count));

  sync_fifo_param #(.SIZE(32), .DEPTH(16), .FWFT(1), .AE_THRESH(2), .AF_THRESH(14)) u_fw (
    .clk(clk), .ainit(ainit), .wr_en(wr_en), .din(din), .rd_en(rd_en), .dout(f_dout),
    .full_f(f_full), .empty_f(f_empty), .almost_full_f(f_af), .almost_empty_f(f_ae),
    .wr_ack(f_wa), .wr_err(f_we), .rd_ack(f_ra), .rd_err(f_re), .count(f_count));

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    n_chk++;
    if (a === e) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", n, a, e);
  endtask

  task automatic check_dut(input string p, input logic [31:0] d, input logic [4:0] c,
                           input logic fu, em, af, ae, wa, we, ra, re, input logic [31:0] ed);
    chk({p, "count"}, 32'(c), 32'(q.size()));
    chk({p, "full_f"}, 32'(fu), 32'(q.size() == 16));
    chk({p, "empty_f"}, 32'(em), 32'(q.size() == 0));
    chk({p, "almost_full_f"}, 32'(af), 32'(q.size() >= 14));
    chk({p, "almost_empty_f"}, 32'(ae), 32'(q.size() <= 2));
    chk({p, "acks"}, 32'({wa, we, ra, re}), 32'({m_wa, m_we, m_ra, m_re}));
    chk({p, "dout"}, d, ed);
  endtask

  task automatic step(input bit r, input bit w, input bit rd, input logic [31:0] d);
    bit wa, ra;
    @(negedge clk);
    ainit = r;
    wr_en = w;
    rd_en = rd;
    din   = d;
    @(posedge clk);
    if (r) begin
      q.delete();
      {m_wa, m_we, m_ra, m_re} = 4'b0;
      m_ds = 0;
      m_df = 0;
    end else begin
      wa = w && q.size() != 16;
      ra = rd && q.size() != 0;
      if (ra) m_ds = q.pop_front();
      if (wa) q.push_back(d);
      if (q.size() != 0) m_df = q[0];
      m_wa = wa;
      m_we = w && !wa;
      m_ra = ra;
      m_re = rd && !ra;
    end
    #1;
    check_dut("std.", s_dout, s_count, s_full, s_empty, s_af, s_ae, s_wa, s_we, s_ra, s_re, m_ds);
    check_dut("fwft.", f_dout, f_count, f_full, f_empty, f_af, f_ae, f_wa, f_we, f_ra, f_re, m_df);
  endtask

  initial begin
    ainit = 1;
    wr_en = 0;
    rd_en = 0;
    din   = 0;
    tbl[0] = '{1, 0, 0, 32'h0,  0, 4'b0000, 32'h0,  32'h0};
    tbl[1] = '{0, 1, 0, 32'hA5, 1, 4'b1000, 32'h0,  32'hA5};
    tbl[2] = '{0, 1, 0, 32'h5A, 2, 4'b1000, 32'h0,  32'hA5};
    tbl[3] = '{0, 0, 1, 32'h0,  1, 4'b0010, 32'hA5, 32'h5A};
    tbl[4] = '{0, 0, 1, 32'h0,  0, 4'b0010, 32'h5A, 32'h5A};
    tbl[5] = '{0, 0, 1, 32'h0,  0, 4'b0001, 32'h5A, 32'h5A};
    tbl[6] = '{0, 1, 1, 32'h77, 1, 4'b1001, 32'h5A, 32'h77};
    tbl[7] = '{0, 1, 1, 32'h88, 1, 4'b1010, 32'h77, 32'h88};
    tbl[8] = '{0, 0, 1, 32'h0,  0, 4'b0010, 32'h88, 32'h88};
    for (int i = 0; i < 9; i++) begin
      step(tbl[i].r, tbl[i].w, tbl[i].rd, tbl[i].d);
      chk($sformatf("vec%0d.count", i), 32'(s_count), tbl[i].cnt);
      chk($sformatf("vec%0d.acks", i), 32'({s_wa, s_we, s_ra, s_re}), 32'(tbl[i].ack));
      chk($sformatf("vec%0d.fwft_acks", i), 32'({f_wa, f_we, f_ra, f_re}), 32'(tbl[i].ack));
      chk($sformatf("vec%0d.std_dout", i), s_dout, tbl[i].ds);
      chk($sformatf("vec%0d.fwft_dout", i), f_dout, tbl[i].df);
    end
    for (int i = 1; i <= 16; i++) begin
      step(0, 1, 0, i);
      chk("fill.wr_ack", 32'(s_wa), 1);
      if (i == 2) chk("fill.ae_after2", 32'(s_ae), 1);
      if (i == 3) chk("fill.ae_after3", 32'(s_ae), 0);
      if (i == 13) chk("fill.af_after13", 32'(s_af), 0);
      if (i == 14) chk("fill.af_after14", 32'(s_af), 1);
    end
    chk("fill.full", 32'(s_full), 1);
    chk("fill.count", 32'(s_count), 16);
    step(0, 1, 0, 17);
    chk("fill.overflow_err", 32'(s_we), 1);
    chk("fill.overflow_count", 32'(s_count), 16);
    for (int i = 1; i <= 16; i++) begin
      step(0, 0, 1, 0);
      chk("drain.dout", s_dout, i);
      chk("drain.rd_ack", 32'(s_ra), 1);
    end
    chk("drain.empty", 32'(s_empty), 1);
    step(0, 0, 1, 0);
    chk("drain.underflow_err", 32'(s_re), 1);
    chk("drain.dout_hold", s_dout, 16);
    for (int i = 0; i < 8; i++) step(0, 1, 0, 100 + i);
    for (int i = 0; i < 40; i++) begin
      step(0, 1, 1, 108 + i);
      chk("wrap.count", 32'(s_count), 8);
      chk("wrap.dout", s_dout, 100 + i);
      chk("wrap.fwft_dout", f_dout, 101 + i);
    end
    step(0, 1, 0, 200);
    step(0, 1, 0, 201);
    chk("midrst.pre_count", 32'(s_count), 10);
    step(1, 1, 1, 202);
    chk("midrst.count", 32'(s_count), 0);
    chk("midrst.empty", 32'(s_empty), 1);
    chk("midrst.acks", 32'({s_wa, s_we, s_ra, s_re}), 0);
    chk("midrst.fwft_dout", f_dout, 0);
    step(0, 1, 0, 32'h77);
    step(0, 0, 1, 0);
    chk("midrst.readback", s_dout, 32'h77);
    for (int i = 0; i < 3000; i++) begin
      int wp;
      wp = ((i / 150) % 2 == 0) ? 75 : 25;
      step($urandom_range(0, 299) == 0, $urandom_range(0, 99) < wp,
           $urandom_range(0, 99) < 100 - wp, $urandom);
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
